// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    // Request payload widths (instruction fetch and load/store share one bus format)
    localparam int unsigned REQ_ADDR_W = 32;
    localparam int unsigned REQ_DATA_W = 32;
    localparam int unsigned REQ_BE_W   = REQ_DATA_W / 8;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Byte-enable patterns for sb / sh / sw
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
        logic                  we;
        logic [REQ_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first request after last_grant.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic        found;
    int unsigned idx;

    // Search last_grant+1 .. last_grant+NUM_REQ with wrap-around
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between NUM_REQ requesters,
// one transaction at a time, with a per-transaction response watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = REQ_ADDR_W,
    parameter int unsigned DATA_W  = REQ_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_be,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic                         resp_err,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_we,
    output logic [DATA_W/8-1:0]          mem_be,
    input  logic                         mem_rvalid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    logic [1:0]         state_q, state_d;
    mem_req_t           req_q, sel_c;
    logic [ID_W-1:0]    id_q, last_q, pick_id_c;
    logic [NUM_REQ-1:0] pick_c;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept_c, done_ok_c, done_err_c, timeout_c;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [DATA_W-1:0]  resp_rdata_q;
    logic               resp_err_q;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (pick_c)
    );

    // Accept is offered only in IDLE and never while reset is asserted
    assign req_ready = (state_q == ST_IDLE && rst) ? pick_c : '0;
    assign accept_c  = (state_q == ST_IDLE) && (|pick_c);

    // cnt_q is the age of the transaction in cycles since accept
    assign timeout_c = (TIMEOUT != 0) && (cnt_q >= CNT_W'(TIMEOUT - 1));

    // Encode the one-hot pick and mux out the winner's request, word aligned
    always_comb begin
        pick_id_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c[i]) pick_id_c = ID_W'(i);
        end
        sel_c          = '0;
        sel_c.addr     = REQ_ADDR_W'(req_addr[int'(pick_id_c)*ADDR_W +: ADDR_W]);
        sel_c.addr[1:0] = 2'b00;
        sel_c.wdata    = REQ_DATA_W'(req_wdata[int'(pick_id_c)*DATA_W +: DATA_W]);
        sel_c.we       = req_we[pick_id_c];
        sel_c.be       = REQ_BE_W'(req_be[int'(pick_id_c)*BE_W +: BE_W]);
    end

    // Next-state logic; a response in the timeout cycle takes priority over the error
    always_comb begin
        state_d    = state_q;
        done_ok_c  = 1'b0;
        done_err_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (timeout_c) begin
                    done_err_c = 1'b1;
                    state_d    = ST_IDLE;
                end else if (mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    done_ok_c = 1'b1;
                    state_d   = ST_IDLE;
                end else if (timeout_c) begin
                    done_err_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Latched request, grant bookkeeping and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q  <= '0;
            id_q   <= '0;
            last_q <= ID_W'(NUM_REQ - 1);
            cnt_q  <= '0;
        end else begin
            if (accept_c) begin
                req_q <= sel_c;
                id_q  <= pick_id_c;
                cnt_q <= CNT_W'(1);
            end else if (state_q != ST_IDLE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done_ok_c || done_err_c) last_q <= id_q;
        end
    end

    // Single-cycle response strobe; data and error hold until the next response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            if (done_ok_c || done_err_c) begin
                resp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
                resp_err_q   <= done_err_c;
                resp_rdata_q <= (done_ok_c && !req_q.we) ? mem_rdata : '0;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_valid  = (state_q == ST_ISSUE);
    assign mem_addr   = ADDR_W'(req_q.addr);
    assign mem_wdata  = DATA_W'(req_q.wdata);
    assign mem_we     = req_q.we;
    assign mem_be     = BE_W'(req_q.be);
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = id_q;

endmodule
